mux_scan_ctrl: RTL and testbench
================================

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1, synchronous active-low reset sampled on rising clk.
REQ-003 SHALL have port start, input, 1, begin scan frame; honoured only in IDLE.
REQ-004 SHALL have port stop, input, 1, abort scan; returns to IDLE on next edge.
REQ-005 SHALL have port cont, input, 1, continuous mode; sampled in DONE.
REQ-006 SHALL have port ch_mask, input, 4, enabled channels (bit n = channel n); latched at start.
REQ-007 SHALL have port dwell, input, 4, settle cycles per channel; latched at start; 0 treated as 1.
REQ-008 SHALL have port Y, input, 1, selected data from the downstream 4:1 mux.
REQ-009 SHALL have port S, output, 2, registered mux select driven to the 4:1 mux.
REQ-010 SHALL have port sample, output, 4, captured value per channel.
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-012 SHALL have port frame_done, output, 1, one-cycle pulse in DONE.
REQ-013 SHALL have port err, output, 1, sticky flag set by start with ch_mask==0.

Function
REQ-014 SHALL implement a Moore FSM with states IDLE, DWELL, CAPTURE, DONE; all outputs registered.
REQ-015 IDLE + start + ch_mask!=0: latch mask/dwell_eff; S <= lowest enabled channel; clear sample bits of disabled channels; cnt <= dwell_eff-1; go DWELL.
REQ-016 IDLE + start + ch_mask==0: stay IDLE, set err; err clears only on reset or next accepted start.
REQ-017 DWELL: cnt decrements each cycle; at cnt==0 go CAPTURE; S held constant.
REQ-018 CAPTURE: sample[S] <= Y on the exiting edge; next higher enabled channel exists -> S <= it, cnt reload, DWELL; else DONE.
REQ-019 Channels scanned ascending only; no wrap within a frame; disabled channels skipped with zero cycles.
REQ-020 DONE: frame_done=1 for one cycle; cont=1 -> restart as REQ-015 with latched mask/dwell (no new latch); cont=0 -> IDLE.
REQ-021 Frame length from start-sampling edge to frame_done cycle SHALL be N*(dwell_eff+1)+1 cycles, N = enabled channels.
REQ-022 stop in any non-IDLE state: next state IDLE, S <= 2'b00, sample retains last values, no frame_done; stop has priority over all transitions.
REQ-023 start while busy SHALL be ignored; ch_mask/dwell changes while busy SHALL have no effect on current frame.
REQ-024 start and stop both high in IDLE: stop wins, stays IDLE, err unchanged.
REQ-025 sample bits of enabled channels not yet captured in a frame SHALL retain prior values until captured.

Reset
REQ-026 rst_n low at a rising edge SHALL force IDLE, S=2'b00, sample=4'b0000, busy=0, frame_done=0, err=0, cnt=0, latched mask/dwell=0.
REQ-027 Reset mid-frame SHALL abandon the frame with no frame_done and takes priority over stop/start.

Verification
REQ-028 mask=1111, dwell=2, Y=S[0]^S[1] via model mux, start 1 cycle -> S sequence 0,1,2,3 each 3 cycles, frame_done 13 cycles after start, sample=4'b0110.
REQ-029 mask=1010, dwell=0, Y=1 -> S 1 then 3, 2 cycles each, frame_done at cycle 5, sample=4'b1010.
REQ-030 mask=0000, start -> err=1, busy=0, no frame_done; then mask=0001 start -> err=0, frame runs.
REQ-031 mask=1111, dwell=3, cont=1 -> frame_done every 17 cycles; change ch_mask to 0001 mid-run -> no effect; stop -> IDLE next edge, S=0.
REQ-032 rst_n low during CAPTURE of channel 2 -> next cycle all outputs at reset values; start asserted in the same cycle is ignored.
REQ-033 start pulsed again while busy with different mask -> ignored, frame completes with original mask and timing.

Source files
------------

// File: rtl/mux_scan_ctrl_if.sv
// Control, status and mux-side signals of the 4:1 mux scan controller.
interface mux_scan_ctrl_if;
    logic       start;
    logic       stop;
    logic       cont;
    logic [3:0] ch_mask;
    logic [3:0] dwell;
    logic       Y;
    logic [1:0] S;
    logic [3:0] sample;
    logic       busy;
    logic       frame_done;
    logic       err;

    modport master (
        output start, stop, cont, ch_mask, dwell, Y,
        input  S, sample, busy, frame_done, err
    );

    modport slave (
        input  start, stop, cont, ch_mask, dwell, Y,
        output S, sample, busy, frame_done, err
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scans enabled channels of a downstream 4:1 mux in ascending order, dwelling
// on each select before capturing Y into the matching sample bit.
module mux_scan_ctrl (
    input  logic           clk,
    input  logic           rst_n,
    mux_scan_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DWELL, CAPTURE, DONE} state_t;

    state_t     state_reg, state_next;
    logic [1:0] s_reg, s_next;
    logic [3:0] sample_reg, sample_next;
    logic [3:0] cnt_reg, cnt_next;
    logic [3:0] mask_reg, mask_next;
    logic [3:0] dwell_reg, dwell_next;
    logic       busy_reg, busy_next;
    logic       frame_done_reg, frame_done_next;
    logic       err_reg, err_next;

    logic [3:0] dwell_eff;
    logic [3:0] above;

    function automatic logic [1:0] lowest(input logic [3:0] m);
        logic [1:0] ch;
        ch = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) ch = 2'(i);
        end
        return ch;
    endfunction

    assign dwell_eff = (bus.dwell == 4'd0) ? 4'd1 : bus.dwell;

    // Latched channels strictly above the current select: candidates for the next hop.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_above
            assign above[gi] = mask_reg[gi] && (s_reg < 2'(gi));
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        s_next      = s_reg;
        sample_next = sample_reg;
        cnt_next    = cnt_reg;
        mask_next   = mask_reg;
        dwell_next  = dwell_reg;
        err_next    = err_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    if (bus.ch_mask == 4'd0) begin
                        err_next = 1'b1;
                    end else begin
                        err_next    = 1'b0;
                        mask_next   = bus.ch_mask;
                        dwell_next  = dwell_eff;
                        s_next      = lowest(bus.ch_mask);
                        sample_next = sample_reg & bus.ch_mask;
                        cnt_next    = dwell_eff - 4'd1;
                        state_next  = DWELL;
                    end
                end
            end
            DWELL: begin
                if (cnt_reg == 4'd0) state_next = CAPTURE;
                else                 cnt_next   = cnt_reg - 4'd1;
            end
            CAPTURE: begin
                sample_next[s_reg] = bus.Y;
                if (above != 4'd0) begin
                    s_next     = lowest(above);
                    cnt_next   = dwell_reg - 4'd1;
                    state_next = DWELL;
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Continuous mode reuses the mask/dwell latched at the original start.
                if (bus.cont) begin
                    s_next      = lowest(mask_reg);
                    sample_next = sample_reg & mask_reg;
                    cnt_next    = dwell_reg - 4'd1;
                    state_next  = DWELL;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (bus.stop && state_reg != IDLE) begin
            state_next  = IDLE;
            s_next      = 2'd0;
            sample_next = sample_reg;
            cnt_next    = 4'd0;
        end

        busy_next       = (state_next != IDLE);
        frame_done_next = (state_next == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            s_reg          <= 2'd0;
            sample_reg     <= 4'd0;
            cnt_reg        <= 4'd0;
            mask_reg       <= 4'd0;
            dwell_reg      <= 4'd0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            s_reg          <= s_next;
            sample_reg     <= sample_next;
            cnt_reg        <= cnt_next;
            mask_reg       <= mask_next;
            dwell_reg      <= dwell_next;
            busy_reg       <= busy_next;
            frame_done_reg <= frame_done_next;
            err_reg        <= err_next;
        end
    end

    assign bus.S          = s_reg;
    assign bus.sample     = sample_reg;
    assign bus.busy       = busy_reg;
    assign bus.frame_done = frame_done_reg;
    assign bus.err        = err_reg;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: table of single frames plus hand-built
// sequences for error, continuous mode, stop and mid-frame reset.
module tb_mux_scan_ctrl;
    logic       clk;
    logic       rst_n;
    logic [3:0] y_data;
    int         tests;
    int         fails;

    mux_scan_ctrl_if bus ();

    // Model of the downstream 4:1 mux.
    assign bus.Y = y_data[bus.S];

    mux_scan_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] mask;
        logic [3:0] dwell;
        logic [3:0] ydata;
        int         exp_len;
        logic [3:0] exp_s1;
        logic [3:0] exp_sample;
        logic       poke;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %0h", name, act);
        end
    endtask

    function automatic logic [1:0] nth_ch(input logic [3:0] m, input int n);
        int         c;
        logic [1:0] r;
        c = 0;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                if (c == n) r = 2'(i);
                c++;
            end
        end
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int         deff;
        int         len_seen;
        logic       s_ok;
        logic       busy_ok;
        logic [1:0] exp_s;
        deff     = (v.dwell == 4'd0) ? 1 : int'(v.dwell);
        len_seen = 0;
        s_ok     = 1'b1;
        busy_ok  = 1'b1;
        y_data      = v.ydata;
        bus.ch_mask = v.mask;
        bus.dwell   = v.dwell;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        check($sformatf("v%0d sample_first_cycle", idx), 32'(bus.sample), 32'(v.exp_s1));
        for (int k = 1; k <= 100; k++) begin
            if (k > 1) tick();
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.frame_done === 1'b1) begin
                len_seen = k;
                break;
            end
            exp_s = nth_ch(v.mask, (k - 1) / (deff + 1));
            if (bus.S !== exp_s && s_ok) begin
                s_ok = 1'b0;
                $display("[TB] v%0d cycle %0d S=%0d expected %0d", idx, k, bus.S, exp_s);
            end
            if (v.poke && k == 2) begin
                bus.start   = 1'b1;
                bus.ch_mask = ~v.mask;
                bus.dwell   = v.dwell + 4'd4;
            end
            if (v.poke && k == 3) bus.start = 1'b0;
        end
        check($sformatf("v%0d frame_len", idx), 32'(len_seen), 32'(v.exp_len));
        check($sformatf("v%0d S_sequence", idx), 32'(s_ok), 32'(1));
        check($sformatf("v%0d busy_in_frame", idx), 32'(busy_ok), 32'(1));
        check($sformatf("v%0d sample", idx), 32'(bus.sample), 32'(v.exp_sample));
        tick();
        check($sformatf("v%0d busy_after", idx), 32'(bus.busy), 32'(0));
        check($sformatf("v%0d frame_done_after", idx), 32'(bus.frame_done), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   nfd;
        int   fd1;
        int   fd2;
        vec_t b;
        tests = 0;
        fails = 0;

        //          mask     dwell  ydata    len s1       sample   poke
        vecs[0] = '{4'b1111, 4'd2,  4'b0110, 13, 4'b0000, 4'b0110, 1'b0};
        vecs[1] = '{4'b1010, 4'd0,  4'b1111,  5, 4'b0010, 4'b1010, 1'b0};
        vecs[2] = '{4'b0100, 4'd5,  4'b0100,  7, 4'b0000, 4'b0100, 1'b0};
        vecs[3] = '{4'b1001, 4'd15, 4'b1001, 33, 4'b0000, 4'b1001, 1'b0};
        vecs[4] = '{4'b0011, 4'd1,  4'b0010,  5, 4'b0001, 4'b0010, 1'b0};
        vecs[5] = '{4'b0011, 4'd1,  4'b0001,  5, 4'b0010, 4'b0001, 1'b1};
        vecs[6] = '{4'b1000, 4'd1,  4'b1000,  3, 4'b0000, 4'b1000, 1'b0};

        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.cont    = 1'b0;
        bus.ch_mask = 4'd0;
        bus.dwell   = 4'd0;
        y_data      = 4'd0;
        tick();
        tick();
        check("reset S", 32'(bus.S), 32'(0));
        check("reset sample", 32'(bus.sample), 32'(0));
        check("reset busy", 32'(bus.busy), 32'(0));
        check("reset frame_done", 32'(bus.frame_done), 32'(0));
        check("reset err", 32'(bus.err), 32'(0));
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Empty mask: error flag, no frame.
        bus.ch_mask = 4'b0000;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        check("zero_mask err", 32'(bus.err), 32'(1));
        check("zero_mask busy", 32'(bus.busy), 32'(0));
        nfd = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.frame_done === 1'b1 || bus.busy === 1'b1) nfd++;
        end
        check("zero_mask no_activity", 32'(nfd), 32'(0));

        // start and stop together in IDLE: stop wins, err untouched.
        bus.ch_mask = 4'b0001;
        bus.start   = 1'b1;
        bus.stop    = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check("start_stop busy", 32'(bus.busy), 32'(0));
        check("start_stop err", 32'(bus.err), 32'(1));

        b = '{4'b0001, 4'd0, 4'b0001, 3, 4'b0000, 4'b0001, 1'b0};
        run_vec(b, 7);
        check("err cleared by start", 32'(bus.err), 32'(0));

        // Continuous mode with mid-run input changes, then stop.
        y_data      = 4'b1100;
        bus.cont    = 1'b1;
        bus.ch_mask = 4'b1111;
        bus.dwell   = 4'd3;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        nfd = 0;
        fd1 = 0;
        fd2 = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) tick();
            if (k == 5) begin
                bus.ch_mask = 4'b0001;
                bus.dwell   = 4'd0;
            end
            if (bus.frame_done === 1'b1) begin
                nfd++;
                if (nfd == 1) fd1 = k;
                else if (nfd == 2) fd2 = k;
            end
        end
        check("cont frame_count", 32'(nfd), 32'(2));
        check("cont first_done", 32'(fd1), 32'(17));
        check("cont second_done", 32'(fd2), 32'(34));
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        bus.cont = 1'b0;
        check("stop busy", 32'(bus.busy), 32'(0));
        check("stop S", 32'(bus.S), 32'(0));
        check("stop frame_done", 32'(bus.frame_done), 32'(0));
        check("stop sample", 32'(bus.sample), 32'(4'b1100));
        tick();
        check("stop stays_idle", 32'(bus.busy), 32'(0));

        // Reset while capturing channel 2, with start asserted alongside.
        y_data      = 4'b1111;
        bus.ch_mask = 4'b1111;
        bus.dwell   = 4'd2;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 2; k <= 9; k++) tick();
        check("rst_mid S_before", 32'(bus.S), 32'(2));
        check("rst_mid sample_before", 32'(bus.sample), 32'(4'b1111));
        rst_n     = 1'b0;
        bus.start = 1'b1;
        tick();
        rst_n     = 1'b1;
        bus.start = 1'b0;
        check("rst_mid S", 32'(bus.S), 32'(0));
        check("rst_mid sample", 32'(bus.sample), 32'(0));
        check("rst_mid busy", 32'(bus.busy), 32'(0));
        check("rst_mid frame_done", 32'(bus.frame_done), 32'(0));
        check("rst_mid err", 32'(bus.err), 32'(0));
        tick();
        check("rst_mid start_ignored", 32'(bus.busy), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
